// File: rtl/poly_input_framer.sv
// Requantizes a serial sfix16_En8 sample stream to sfix11_En3 (round half up, saturate)
// and packs every LANES samples into one frame held for a valid/ready consumer.
module poly_input_framer #(
  parameter int IN_W  = 16,
  parameter int SHIFT = 5,
  parameter int OUT_W = 11,
  parameter int LANES = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [IN_W-1:0]         in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  output logic signed [OUT_W-1:0] out_data [0:LANES-1],
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [1:0]              lane_idx,
  output logic [7:0]              sat_cnt
);

  localparam int          TW   = IN_W - SHIFT + 1;
  localparam logic [1:0]  LAST = 2'(LANES - 1);
  localparam logic [IN_W:0] RND = (IN_W + 1)'(2 ** (SHIFT - 1));
  localparam logic signed [TW-1:0] QMAX = TW'(2 ** (OUT_W - 1) - 1);
  localparam logic signed [TW-1:0] QMIN = TW'(-(2 ** (OUT_W - 1)));

  // Handshakes: a transfer happens on a clock edge where valid && ready are both 1.
  // ready never depends on the same side's valid; valid/data are held until the transfer.

  logic [IN_W:0]            sum;
  logic signed [TW-1:0]     t;
  logic                     sat_hi;
  logic                     sat_lo;
  logic signed [OUT_W-1:0]  q;
  logic                     accept;
  logic                     complete;
  logic signed [OUT_W-1:0]  asm_q [0:LANES-1];

  // Sign-extend to 17 bits before adding the half-LSB so the top sample cannot wrap.
  assign sum    = {in_data[IN_W-1], in_data} + RND;
  assign t      = sum[IN_W:SHIFT];
  assign sat_hi = (t > QMAX);
  assign sat_lo = (t < QMIN);

  always_comb begin
    q = t[OUT_W-1:0];
    if (sat_hi) q = {1'b0, {(OUT_W-1){1'b1}}};
    if (sat_lo) q = {1'b1, {(OUT_W-1){1'b0}}};
  end

  // A completing sample needs the output slot empty or draining this cycle.
  assign in_ready = !flush && !((lane_idx == LAST) && out_valid && !out_ready);
  assign accept   = in_valid && in_ready;
  assign complete = accept && (lane_idx == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      lane_idx  <= 2'd0;
      out_valid <= 1'b0;
      sat_cnt   <= 8'd0;
      for (int i = 0; i < LANES; i++) begin
        out_data[i] <= '0;
        asm_q[i]    <= '0;
      end
    end else begin
      if (flush) begin
        lane_idx <= 2'd0;
      end else if (accept) begin
        asm_q[lane_idx] <= q;
        lane_idx        <= complete ? 2'd0 : lane_idx + 2'd1;
      end

      if (complete) begin
        for (int i = 0; i < LANES - 1; i++) out_data[i] <= asm_q[i];
        out_data[LANES-1] <= q;
        out_valid         <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      if (accept && (sat_hi || sat_lo) && (sat_cnt != 8'hFF)) begin
        sat_cnt <= sat_cnt + 8'd1;
      end
    end
  end

endmodule
